// File: rtl/sseg_pkg.sv
//------------------------------------------------------------------------------
// Module  : sseg_pkg
// Brief   : Shared types and constants for the seven-segment scan driver.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sseg_pkg;

  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_NONE   = 8'hFF;

  typedef logic [2:0] digit_idx_t;
  typedef logic [7:0] seg_t;

  // Active-low one-cold anode pattern for the selected digit.
  function automatic seg_t anode_drive(input digit_idx_t idx);
    return ~(seg_t'(1) << idx);
  endfunction

endpackage : sseg_pkg

`default_nettype wire

// File: rtl/sseg_slot_timer.sv
//------------------------------------------------------------------------------
// Module  : sseg_slot_timer
// Brief   : Free-running refresh counter; yields digit select, PWM phase,
//           slot dead-time window (SSEG_DEADTIME_EN) and the frame tick.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sseg_slot_timer
  import sseg_pkg::*;
#(
  parameter int N      = 18,
  parameter int DEAD_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  output digit_idx_t sel,
  output logic [3:0] ph,
  output logic       dead,
  output logic       frame_tick
);

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt_q, cnt_d;
  logic         frame_tick_q, frame_tick_d;

  if (N < 8 || DEAD_W > N - 4) begin : g_bad_params
    $error("sseg_slot_timer: need N >= 8 and DEAD_W <= N-4");
  end

  always_comb begin
    cnt_d        = cnt_q + CNT_ONE;
    frame_tick_d = &cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = cnt_q[N-1:N-3];
  assign ph         = cnt_q[N-4:N-7];
  assign frame_tick = frame_tick_q;

`ifdef SSEG_DEADTIME_EN
  // First 2^DEAD_W cycles of each slot keep every anode off.
  assign dead = (cnt_q[N-4:DEAD_W] == '0);
`else
  assign dead = 1'b0;
`endif

endmodule : sseg_slot_timer

`default_nettype wire

// File: rtl/sseg_scan_driver.sv
//------------------------------------------------------------------------------
// Module  : sseg_scan_driver
// Brief   : 8-digit common-anode scan driver with blanking, PWM dimming and a
//           frame tick. Optional anode dead time via SSEG_DEADTIME_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N      = 18,
  parameter int DEAD_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  input  logic [7:0] dig_en,
  input  logic [3:0] bright,
  output logic [7:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  digit_idx_t sel;
  logic [3:0] ph;
  logic       dead;
  logic       lit;
  seg_t       digit_seg;
  seg_t       an_q, an_d;
  seg_t       sseg_q, sseg_d;

  sseg_slot_timer #(
    .N      (N),
    .DEAD_W (DEAD_W)
  ) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .ph         (ph),
    .dead       (dead),
    .frame_tick (frame_tick)
  );

  always_comb begin
    digit_seg = in0;
    case (sel)
      3'd0:    digit_seg = in0;
      3'd1:    digit_seg = in1;
      3'd2:    digit_seg = in2;
      3'd3:    digit_seg = in3;
      3'd4:    digit_seg = in4;
      3'd5:    digit_seg = in5;
      3'd6:    digit_seg = in6;
      default: digit_seg = in7;
    endcase
  end

  // Phase compare gives (bright+1)/16 duty; only dig_en can fully darken.
  always_comb begin
    lit    = dig_en[sel] & (ph <= bright) & ~dead;
    an_d   = AN_NONE;
    sseg_d = SEG_BLANK;
    if (lit) begin
      an_d   = anode_drive(sel);
      sseg_d = digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= AN_NONE;
      sseg_q <= SEG_BLANK;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule : sseg_scan_driver

`default_nettype wire
